// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, flag indices and FSM encoding
// shared by alu_pipe and alu_div_seq.
package alu_pipe_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_NOR  = 2'd3;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_EQ  = 2'd1;
  localparam logic [1:0] OP_GT  = 2'd2;
  localparam logic [1:0] OP_LT  = 2'd3;

  localparam logic [1:0] OP_SHR = 2'd0;
  localparam logic [1:0] OP_SHL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_ROL = 2'd3;

  localparam logic [3:0] FUN_DIV = {UNIT_ARITH, OP_DIV};

  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_ERR = 3;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async low), start (loads operands),
//   dividend, divisor, done (last iteration this cycle),
//   quotient, remainder, div0 (divisor was zero).
module alu_div_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div0
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic [W-1:0]  d;
  logic [W:0]    trial;

  // bit W set means the trial subtraction went negative
  assign trial = {r, q[W-1]} - {1'b0, d};
  assign done  = busy & (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
      div0 <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
      div0 <= (divisor == '0);
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(W - 1))
        busy <= 1'b0;
      // a zero divisor never goes negative: q fills
      // with ones and r ends up holding the dividend
      if (!trial[W]) begin
        r <= trial[W-1:0];
        q <= {q[W-2:0], 1'b1};
      end else begin
        r <= {r[W-2:0], q[W-1]};
        q <= {q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked W-bit ALU with registered 2W result
// and {ERR,V,C,Z} flags. Inputs: CLK, RST (async low), A, B,
// ALU_FUN, IN_VALID, OUT_READY. Outputs: IN_READY, ALU_OUT,
// FLAGS, OUT_VALID. Define ALU_DIV_EN to build the divider.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic [3:0]            FLAGS,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);

  state_t         state_q;
  logic           div_busy;
  logic           accept;
  logic           out_free;
  logic           out_load;

  logic           ex_vld;
  logic [3:0]     ex_fun;
  logic [W-1:0]   ex_a;
  logic [W-1:0]   ex_b;

  logic [OUT_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] dif;
  logic [OUT_WIDTH-1:0] prod;
  logic [W-1:0]         rol;
  logic [SW-1:0]        sh;
  logic [OUT_WIDTH-1:0] res;
  logic [3:0]           flg;

  assign out_free = ~OUT_VALID | OUT_READY;
  assign div_busy = (state_q == DIV);
  assign IN_READY = ~div_busy & out_free;
  assign accept   = IN_VALID & IN_READY;
  // the ex slot completes unless a divide is still iterating
  assign out_load = ex_vld & ~div_busy & out_free;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_vld <= 1'b0;
      ex_fun <= '0;
      ex_a   <= '0;
      ex_b   <= '0;
    end else if (accept) begin
      ex_vld <= 1'b1;
      ex_fun <= ALU_FUN;
      ex_a   <= A;
      ex_b   <= B;
    end else if (out_load) begin
      ex_vld <= 1'b0;
    end
  end

`ifdef ALU_DIV_EN
  state_t       state_d;
  logic         div_start;
  logic         div_done;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         div_zero;

  assign div_start = accept & (ALU_FUN == FUN_DIV);

  alu_div_seq #(
    .DATA_WIDTH (W)
  ) u_div (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (div_start),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r),
    .div0      (div_zero)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (div_start) state_d = DIV;
      DIV:  if (div_done)  state_d = IDLE;
    endcase
  end
`else
  assign state_q = IDLE;
`endif

  assign sum  = {{W{1'b0}}, ex_a} + {{W{1'b0}}, ex_b};
  assign dif  = {{W{1'b0}}, ex_a} - {{W{1'b0}}, ex_b};
  assign prod = {{W{1'b0}}, ex_a} * {{W{1'b0}}, ex_b};
  assign sh   = ex_b[SW-1:0];

  // W is a power of two, so SW-bit index wraps mod W
  always_comb begin
    rol = '0;
    for (int i = 0; i < W; i++)
      rol[i] = ex_a[SW'(i - int'(sh))];
  end

  always_comb begin
    res = '0;
    flg = '0;
    unique case (ex_fun[3:2])
      UNIT_ARITH: begin
        unique case (ex_fun[1:0])
          OP_ADD: begin
            res = sum;
            flg[FLAG_C] = sum[W];
            flg[FLAG_V] = (ex_a[W-1] == ex_b[W-1]) &
                          (sum[W-1] != ex_a[W-1]);
          end
          OP_SUB: begin
            res = dif;
            flg[FLAG_C] = (ex_a < ex_b);
            flg[FLAG_V] = (ex_a[W-1] != ex_b[W-1]) &
                          (dif[W-1] != ex_a[W-1]);
          end
          OP_MUL: res = prod;
          OP_DIV: begin
`ifdef ALU_DIV_EN
            res = {div_r, div_q};
            flg[FLAG_ERR] = div_zero;
`else
            flg[FLAG_ERR] = 1'b1;
`endif
          end
        endcase
      end
      UNIT_LOGIC: begin
        unique case (ex_fun[1:0])
          OP_AND:  res = {{W{1'b0}}, ex_a & ex_b};
          OP_OR:   res = {{W{1'b0}}, ex_a | ex_b};
          OP_NAND: res = {{W{1'b0}}, ~(ex_a & ex_b)};
          OP_NOR:  res = {{W{1'b0}}, ~(ex_a | ex_b)};
        endcase
      end
      UNIT_CMP: begin
        unique case (ex_fun[1:0])
          OP_NOP: res = '0;
          OP_EQ:
            res = (ex_a == ex_b) ? OUT_WIDTH'(1) : '0;
          OP_GT:
            res = (ex_a > ex_b) ? OUT_WIDTH'(2) : '0;
          OP_LT:
            res = (ex_a < ex_b) ? OUT_WIDTH'(3) : '0;
        endcase
      end
      UNIT_SHIFT: begin
        unique case (ex_fun[1:0])
          OP_SHR: res = {{W{1'b0}}, ex_a >> sh};
          OP_SHL: res = {{W{1'b0}}, ex_a << sh};
          OP_SRA:
            res = {{W{1'b0}}, $signed(ex_a) >>> sh};
          OP_ROL: res = {{W{1'b0}}, rol};
        endcase
      end
    endcase
    flg[FLAG_Z] = (res == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT   <= '0;
      FLAGS     <= '0;
    end else if (out_load) begin
      OUT_VALID <= 1'b1;
      ALU_OUT   <= res;
      FLAGS     <= flg;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (W=8) with a
// behavioural scoreboard checked on every valid output cycle.
module tb_alu_pipe;
  localparam int W = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [3:0]  ALU_FUN = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] ALU_OUT;
  logic [3:0]  FLAGS;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;

  always #5 CLK = ~CLK;

  alu_pipe #(.DATA_WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_OUT   (ALU_OUT),
    .FLAGS     (FLAGS),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  int n_run = 0;
  int n_fail = 0;
  int last_wait = 0;
  bit rnd_rdy = 1'b0;
  logic [19:0] exp_q[$];

  logic [19:0] vecs [0:21] = '{
    20'h07F01, 20'h08080, 20'h11010, 20'h2FFFF,
    20'h20037, 20'h4F0AA, 20'h50F30, 20'h6FFFF,
    20'h70000, 20'h81234, 20'h95555, 20'h95556,
    20'hAA903, 20'hB0309, 20'hC8003, 20'hD8101,
    20'hE8003, 20'hE4002, 20'hF8108, 20'h3FF10,
    20'h3C801, 20'hF4307
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // {ERR,V,C,Z, result[15:0]} from the arithmetic rules
  function automatic logic [19:0] model(
    input logic [3:0] fun,
    input logic [7:0] a,
    input logic [7:0] b);
    int ia, ib, sa, sb, r, s;
    bit c, v, e;
    ia = a; ib = b;
    sa = $signed(a); sb = $signed(b);
    s = ib % 8;
    r = 0; c = 0; v = 0; e = 0;
    case (fun)
      4'h0: begin
        r = ia + ib;
        c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'h1: begin
        r = (ia - ib) & 'hFFFF;
        c = (ia < ib);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      4'h2: r = ia * ib;
      4'h3: begin
`ifdef ALU_DIV_EN
        if (ib == 0) begin
          r = ia * 256 + 255;
          e = 1;
        end else begin
          r = (ia % ib) * 256 + ia / ib;
        end
`else
        e = 1;
`endif
      end
      4'h4: r = ia & ib;
      4'h5: r = ia | ib;
      4'h6: r = ~(ia & ib) & 255;
      4'h7: r = ~(ia | ib) & 255;
      4'h8: r = 0;
      4'h9: r = (ia == ib) ? 1 : 0;
      4'hA: r = (ia > ib) ? 2 : 0;
      4'hB: r = (ia < ib) ? 3 : 0;
      4'hC: r = ia >> s;
      4'hD: r = (ia << s) & 255;
      4'hE: r = (sa >>> s) & 255;
      default: r = ((ia << s) | (ia >> (8 - s))) & 255;
    endcase
    return {e, v, c, (r == 0), r[15:0]};
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      exp_q.delete();
    end else begin
      if (OUT_VALID) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", OUT_VALID, 0);
        end else begin
          chk("sb_data", ALU_OUT, exp_q[0][15:0]);
          chk("sb_flags", FLAGS, exp_q[0][19:16]);
          if (OUT_READY) void'(exp_q.pop_front());
        end
      end
      if (IN_VALID && IN_READY)
        exp_q.push_back(model(ALU_FUN, A, B));
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // call just after a rising edge; returns just after
  // the accepting edge
  task automatic send(input logic [3:0] f,
                      input logic [7:0] a,
                      input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    last_wait = 0;
    ALU_FUN = f; A = a; B = b; IN_VALID = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      last_wait++;
      if (rnd_rdy)
        OUT_READY = ($urandom_range(0, 3) != 0);
    end
    IN_VALID = 1'b0;
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic wait_valid(output int lat,
                            output int lows);
    lat = 0;
    lows = 0;
    @(negedge CLK);
    while (!OUT_VALID && lat < 50) begin
      if (!IN_READY) lows++;
      lat++;
      @(negedge CLK);
    end
    if (!OUT_VALID) chk("valid_timeout", OUT_VALID, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lows;
    logic [19:0] m;

    m = model(4'hE, 8'h80, 8'h03);
    chk("model_sra", m, 20'h000F0);
    m = model(4'h2, 8'hFF, 8'hFF);
    chk("model_mul", m, 20'h0FE01);
    m = model(4'h0, 8'h80, 8'h80);
    chk("model_add_cv", m, 20'h60100);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    sync();
    @(negedge CLK);
    chk("rst_out", ALU_OUT, 0);
    chk("rst_flags", FLAGS, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    sync();

    send(4'h0, 8'hFF, 8'h01);
    wait_valid(lat, lows);
    chk("add_lat", lat, 1);
    chk("add_out", ALU_OUT, 16'h0100);
    chk("add_flags", FLAGS, 4'b0010);
    sync();

    send(4'h1, 8'h05, 8'h07);
    wait_valid(lat, lows);
    chk("sub_out", ALU_OUT, 16'hFFFE);
    chk("sub_flags", FLAGS, 4'b0010);
    sync();

    send(4'h1, 8'h80, 8'h01);
    wait_valid(lat, lows);
    chk("sub_v_out", ALU_OUT, 16'h007F);
    chk("sub_v_flags", FLAGS, 4'b0100);
    sync();

    send(4'h3, 8'd100, 8'd7);
    wait_valid(lat, lows);
`ifdef ALU_DIV_EN
    chk("div_lat", lat, 9);
    chk("div_busy_cycles", lows, 8);
    chk("div_out", ALU_OUT, 16'h020E);
    chk("div_flags", FLAGS, 4'b0000);
`else
    chk("div_lat", lat, 1);
    chk("div_busy_cycles", lows, 0);
    chk("div_out", ALU_OUT, 16'h0000);
    chk("div_flags", FLAGS, 4'b1001);
`endif
    sync();

    send(4'h3, 8'h2A, 8'h00);
    wait_valid(lat, lows);
`ifdef ALU_DIV_EN
    chk("div0_lat", lat, 9);
    chk("div0_out", ALU_OUT, 16'h2AFF);
    chk("div0_flags", FLAGS, 4'b1000);
`else
    chk("div0_lat", lat, 1);
    chk("div0_out", ALU_OUT, 16'h0000);
    chk("div0_flags", FLAGS, 4'b1001);
`endif
    sync();

    send(4'hF, 8'h81, 8'h09);
    wait_valid(lat, lows);
    chk("rol_out", ALU_OUT, 16'h0003);
    chk("rol_flags", FLAGS, 4'b0000);
    sync();

    OUT_READY = 1'b0;
    send(4'h0, 8'd1, 8'd2);
    send(4'h0, 8'd3, 8'd4);
    @(negedge CLK);
    chk("bp_valid", OUT_VALID, 1);
    chk("bp_out", ALU_OUT, 16'h0003);
    chk("bp_in_ready", IN_READY, 0);
    sync();
    @(negedge CLK);
    chk("bp_hold", ALU_OUT, 16'h0003);
    sync();
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_rel_out", ALU_OUT, 16'h0003);
    chk("bp_rel_in_ready", IN_READY, 1);
    sync();
    @(negedge CLK);
    chk("bp_next_valid", OUT_VALID, 1);
    chk("bp_next_out", ALU_OUT, 16'h0007);
    sync();
    sync();

    send(4'h3, 8'd200, 8'd3);
    repeat (3) sync();
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_out", ALU_OUT, 0);
    sync();
    @(negedge CLK);
    RST = 1'b1;
    sync();
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);
    chk("post_rst_valid", OUT_VALID, 0);
    sync();
    send(4'h4, 8'hF0, 8'h3C);
    wait_valid(lat, lows);
    chk("and_out", ALU_OUT, 16'h0030);
    sync();

    for (int i = 0; i < 4; i++) begin
      send(4'h2, 8'(i + 3), 8'(i + 5));
      if (i > 0) chk("throughput", last_wait, 1);
    end
    sync();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 22; i++)
      send(vecs[i][19:16], vecs[i][15:8], vecs[i][7:0]);
    rnd_rdy = 1'b0;
    OUT_READY = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++)
      @(negedge CLK);
    chk("drain", exp_q.size(), 0);
    sync();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
